// File: rtl/fp_expand.sv
// fp_expand: serial expansion of a 1/3/4 sign-exponent-mantissa word into a
// 12-bit two's-complement value, one shift per cycle.
module fp_expand (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [2:0]  exp,
    input  logic [3:0]  mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] dec
);
    typedef enum logic [1:0] {IDLE, SHIFT, NEG, DONE} state_t;
    state_t      state;
    logic [11:0] acc;
    logic [2:0]  cnt;
    logic        neg;
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign dec       = acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 12'd0;
            cnt   <= 3'd0;
            neg   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    neg   <= sign;
                    cnt   <= exp;
                    acc   <= {8'b0, mant};
                    state <= (exp != 3'd0) ? SHIFT : NEG;
                end
                SHIFT: begin
                    acc   <= acc << 1;
                    cnt   <= cnt - 3'd1;
                    state <= (cnt == 3'd1) ? NEG : SHIFT;
                end
                NEG: begin
                    acc   <= neg ? (~acc) + 12'd1 : acc;
                    state <= DONE;
                end
                DONE: state <= out_ready ? IDLE : DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_expand.sv
// tb_fp_expand: directed and randomized checks of fp_expand against an
// arithmetic reference model.
module tb_fp_expand;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        sign = 1'b0;
    logic [2:0]  exp = 3'd0;
    logic [3:0]  mant = 4'd0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] dec;
    int          n_checks = 0;
    int          n_pass = 0;

    fp_expand dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp), .mant(mant), .out_valid(out_valid),
        .out_ready(out_ready), .dec(dec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    function automatic int model(input bit s, input int e, input int m);
        int v;
        v = m * (1 << e);
        if (s) v = -v;
        return v & 32'hfff;
    endfunction

    task automatic scramble();
        in_valid = 1'($urandom);
        sign     = 1'($urandom);
        exp      = 3'($urandom);
        mant     = 4'($urandom);
    endtask

    task automatic xact(input bit s, input int e, input int m, input int hold, input string tag);
        int lat;
        int want;
        want = model(s, e, m);
        @(negedge clk);
        check({tag, ".in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        sign = s;
        exp  = 3'(e);
        mant = 4'(m);
        @(posedge clk);
        #1 scramble();
        @(negedge clk);
        check({tag, ".busy_ready"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1 scramble();
            @(negedge clk);
        end
        check({tag, ".latency"}, lat, e + 1);
        check({tag, ".dec"}, int'(dec), want);
        for (int i = 0; i < hold; i++) begin
            scramble();
            @(negedge clk);
            check({tag, ".hold_dec"}, int'(dec), want);
            check({tag, ".hold_valid"}, int'(out_valid), 1);
            check({tag, ".hold_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".post_valid"}, int'(out_valid), 0);
        check({tag, ".post_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int stray;
        #1 rst = 1'b1;
        #1;
        check("reset.valid", int'(out_valid), 0);
        check("reset.dec", int'(dec), 0);
        check("reset.ready", int'(in_ready), 0);
        #20 rst = 1'b0;
        #1 check("release.ready", int'(in_ready), 1);

        xact(1'b0, 0, 0, 0, "zero");
        xact(1'b0, 5, 13, 0, "p416");
        xact(1'b1, 7, 15, 1, "n1920");
        xact(1'b1, 2, 5, 0, "n20");
        xact(1'b1, 3, 0, 0, "negzero");
        xact(1'b0, 1, 3, 5, "backpressure");

        @(negedge clk);
        in_valid = 1'b1;
        sign = 1'b0;
        exp  = 3'd7;
        mant = 4'd15;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort.valid", int'(out_valid), 0);
        check("abort.dec", int'(dec), 0);
        check("abort.ready", int'(in_ready), 0);
        #2 rst = 1'b0;
        #1 check("abort.release_ready", int'(in_ready), 1);
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || dec != 12'd0) stray++;
        end
        check("abort.stale", stray, 0);

        for (int i = 0; i < 40; i++)
            xact(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
